io_port_bank: RTL and testbench

IO_PORT_BANK -- requirements
Module: io_port_bank

---
 rtl/io_pkg.sv | 17 +
 rtl/io_channel.sv | 79 +++++++
 rtl/io_port_bank.sv | 116 +++++++++++
 tb/tb_io_port_bank.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Register address map and sizing limits for io_port_bank.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam logic [3:0] ADDR_MASK    = 4'hC;
    localparam logic [3:0] ADDR_OVF     = 4'hD;
    localparam logic [3:0] ADDR_INFULL  = 4'hE;
    localparam logic [3:0] ADDR_OUTBUSY = 4'hF;

    localparam int NPORTS_MAX = 8;

endpackage : io_pkg
`default_nettype wire

// File: rtl/io_channel.sv
`default_nettype none
// ============================================================================
// Module      : io_channel
// Description : One input/output channel pair: holding register with full
//               flag, output register with busy flag, sticky overflow bit.
// Revision    : 1.0 - initial release
// ============================================================================
module io_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_full,
    output logic [WIDTH-1:0] o_hold,
    input  logic             i_rd_clr,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    input  logic             i_ovf_clr,
    output logic             o_ovf
);

    logic             r_in_ready;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_out;
    logic             r_busy;
    logic             r_ovf;

    logic w_capture;
    logic w_hs;
    logic w_wr_ok;
    logic w_wr_drop;

    assign w_capture = i_in_valid & r_in_ready;
    assign w_hs      = r_busy & i_out_ready;
    // A write landing on the handshake cycle replaces the departing word.
    assign w_wr_ok   = i_wr_en & (~r_busy | w_hs);
    assign w_wr_drop = i_wr_en & r_busy & ~i_out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready <= 1'b1;
            r_hold     <= '0;
            r_out      <= '0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_hold     <= i_in_data;
                r_in_ready <= 1'b0;
            end else if (i_rd_clr) begin
                r_in_ready <= 1'b1;
            end

            if (w_wr_ok) begin
                r_out  <= i_wr_data;
                r_busy <= 1'b1;
            end else if (w_hs) begin
                r_busy <= 1'b0;
            end

            r_ovf <= (r_ovf & ~i_ovf_clr) | w_wr_drop;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_full      = ~r_in_ready;
    assign o_hold      = r_hold;
    assign o_out_data  = r_out;
    assign o_out_valid = r_busy;
    assign o_ovf       = r_ovf;

endmodule : io_channel
`default_nettype wire

// File: rtl/io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bank
// Description : CPU-mapped bank of NPORTS input/output channels with status
//               masks. Define IO_IRQ_EN to add the IRQ mask and irq output.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_bank
    import io_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NPORTS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              cpu_addr,
    input  logic                    cpu_we,
    input  logic                    cpu_re,
    input  logic [WIDTH-1:0]        cpu_wdata,
    output logic [WIDTH-1:0]        cpu_rdata,
    input  logic [NPORTS*WIDTH-1:0] in_data,
    input  logic [NPORTS-1:0]       in_valid,
    output logic [NPORTS-1:0]       in_ready,
    output logic [NPORTS*WIDTH-1:0] out_data,
    output logic [NPORTS-1:0]       out_valid,
    input  logic [NPORTS-1:0]       out_ready
`ifdef IO_IRQ_EN
    ,
    output logic                    irq
`endif
);

    logic [NPORTS-1:0]            w_full;
    logic [NPORTS-1:0]            w_busy;
    logic [NPORTS-1:0]            w_ovf;
    logic [NPORTS-1:0][WIDTH-1:0] w_hold;
    logic                         w_ovf_clr;
    logic [WIDTH-1:0]             w_rd;

    if (NPORTS < 1 || NPORTS > NPORTS_MAX || NPORTS > WIDTH) begin : g_bad_nports
        $error("io_port_bank: NPORTS out of range");
    end

    assign w_ovf_clr = cpu_re && (cpu_addr == ADDR_OVF);

    for (genvar i = 0; i < NPORTS; i++) begin : g_chan
        io_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .i_in_data   (in_data[i*WIDTH +: WIDTH]),
            .i_in_valid  (in_valid[i]),
            .o_in_ready  (in_ready[i]),
            .o_full      (w_full[i]),
            .o_hold      (w_hold[i]),
            .i_rd_clr    (cpu_re && (cpu_addr == 4'(i))),
            .i_wr_en     (cpu_we && (cpu_addr == 4'(i))),
            .i_wr_data   (cpu_wdata),
            .o_out_data  (out_data[i*WIDTH +: WIDTH]),
            .o_out_valid (out_valid[i]),
            .i_out_ready (out_ready[i]),
            .i_ovf_clr   (w_ovf_clr),
            .o_ovf       (w_ovf[i])
        );
        assign w_busy[i] = out_valid[i];
    end

`ifdef IO_IRQ_EN
    logic [NPORTS-1:0] r_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
            irq    <= 1'b0;
        end else begin
            if (cpu_we && (cpu_addr == ADDR_MASK)) begin
                r_mask <= cpu_wdata[NPORTS-1:0];
            end
            irq <= |((w_full | w_ovf) & r_mask);
        end
    end
`endif

    // Status masks are zero-extended; anything unmapped reads as zero.
    always_comb begin
        w_rd = '0;
        case (cpu_addr)
`ifdef IO_IRQ_EN
            ADDR_MASK:    w_rd[NPORTS-1:0] = r_mask;
`else
            ADDR_MASK:    w_rd = '0;
`endif
            ADDR_OVF:     w_rd[NPORTS-1:0] = w_ovf;
            ADDR_INFULL:  w_rd[NPORTS-1:0] = w_full;
            ADDR_OUTBUSY: w_rd[NPORTS-1:0] = w_busy;
            default: begin
                for (int k = 0; k < NPORTS; k++) begin
                    if (cpu_addr == 4'(k)) begin
                        w_rd = w_hold[k];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata <= '0;
        end else if (cpu_re) begin
            cpu_rdata <= w_rd;
        end
    end

endmodule : io_port_bank
`default_nettype wire

// File: tb/tb_io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_bank
// Description : Directed and randomized self-checking bench for io_port_bank
//               against a register-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_bank;

    localparam int W  = 8;
    localparam int NP = 2;

    logic              clk;
    logic              reset;
    logic [3:0]        cpu_addr;
    logic              cpu_we;
    logic              cpu_re;
    logic [W-1:0]      cpu_wdata;
    logic [W-1:0]      cpu_rdata;
    logic [NP*W-1:0]   in_data;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [NP*W-1:0]   out_data;
    logic [NP-1:0]     out_valid;
    logic [NP-1:0]     out_ready;
`ifdef IO_IRQ_EN
    logic              irq;
`endif

    io_port_bank #(
        .WIDTH  (W),
        .NPORTS (NP)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef IO_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Register-level picture of the bank
    bit   [NP-1:0] m_full, m_busy, m_ovf, m_mask;
    logic [W-1:0]  m_hold [NP];
    logic [W-1:0]  m_out  [NP];
    logic [W-1:0]  m_rdata;
    bit            m_irq;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = '0; m_busy = '0; m_ovf = '0; m_mask = '0;
        m_rdata = '0; m_irq = 1'b0;
        for (int i = 0; i < NP; i++) begin
            m_hold[i] = '0;
            m_out[i]  = '0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0]  rd;
        logic [NP-1:0] set_ovf;
        bit            irq_n;
        bit            hs;
        int            a;
        a       = int'(cpu_addr);
        rd      = m_rdata;
        set_ovf = '0;
        if (cpu_re) begin
            rd = '0;
            if (a < NP) rd = m_hold[a];
            else if (a == 12) rd = W'(m_mask);
            else if (a == 13) rd = W'(m_ovf);
            else if (a == 14) rd = W'(m_full);
            else if (a == 15) rd = W'(m_busy);
        end
        irq_n = |((m_full | m_ovf) & m_mask);
        for (int i = 0; i < NP; i++) begin
            if (!m_full[i] && in_valid[i]) begin
                m_hold[i] = in_data[i*W +: W];
                m_full[i] = 1'b1;
            end else if (m_full[i] && cpu_re && a == i) begin
                m_full[i] = 1'b0;
            end
            hs = m_busy[i] && out_ready[i];
            if (cpu_we && a == i) begin
                if (!m_busy[i] || hs) begin
                    m_out[i]  = cpu_wdata;
                    m_busy[i] = 1'b1;
                end else begin
                    set_ovf[i] = 1'b1;
                end
            end else if (hs) begin
                m_busy[i] = 1'b0;
            end
        end
        if (cpu_re && a == 13) m_ovf = '0;
        m_ovf = m_ovf | set_ovf;
`ifdef IO_IRQ_EN
        if (cpu_we && a == 12) m_mask = cpu_wdata[NP-1:0];
`endif
        m_rdata = rd;
        m_irq   = irq_n;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        cpu_addr = '0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wdata = '0;
        in_data = '0; in_valid = '0; out_ready = '0;
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, {NP{1'b1}});
        chk("rst_rdata",     cpu_rdata, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Continuous comparison against the model
    always @(negedge clk) begin
        logic [NP-1:0] exp_rdy;
        if (chk_en && !reset) begin
            exp_rdy = ~m_full;
            chk("in_ready",  in_ready,  exp_rdy);
            chk("out_valid", out_valid, m_busy);
            chk("cpu_rdata", cpu_rdata, m_rdata);
            for (int i = 0; i < NP; i++) begin
                chk($sformatf("out_data%0d", i), out_data[i*W +: W], m_out[i]);
            end
`ifdef IO_IRQ_EN
            chk("irq", irq, m_irq);
`endif
        end
    end

    initial begin
        reset = 1'b1;
        set_idle();
        model_reset();
        repeat (3) @(negedge clk);
        chk("init_in_ready",  in_ready, 2'b11);
        chk("init_out_valid", out_valid, 0);
        chk("init_rdata",     cpu_rdata, 0);
        reset  = 1'b0;
        chk_en = 1'b1;
        cycle();

        // input capture and read
        in_valid = 2'b01; in_data = 16'h005A;
        cycle();
        chk("cap_in_ready0", in_ready[0], 0);
        in_valid = '0; cpu_re = 1'b1; cpu_addr = 4'h0;
        cycle();
        chk("cap_rdata", cpu_rdata, 8'h5A);
        chk("cap_in_ready0_after", in_ready[0], 1);
        set_idle();

        // output backpressure and overflow
        cpu_we = 1'b1; cpu_addr = 4'h1; cpu_wdata = 8'h33;
        cycle();
        chk("bp_out_valid1", out_valid[1], 1);
        chk("bp_out_data1", out_data[15:8], 8'h33);
        cpu_wdata = 8'h44;
        cycle();
        chk("bp_out_data1_kept", out_data[15:8], 8'h33);
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 4'hD;
        cycle();
        chk("bp_ovf_read", cpu_rdata, 8'h02);
        cycle();
        chk("bp_ovf_clear", cpu_rdata, 8'h00);
        set_idle(); out_ready = 2'b10;
        cycle();
        chk("bp_drained", out_valid[1], 0);
        set_idle();

        // write lands on the handshake cycle
        cpu_we = 1'b1; cpu_addr = 4'h0; cpu_wdata = 8'h10;
        cycle();
        chk("b2b_first", out_data[7:0], 8'h10);
        out_ready = 2'b01; cpu_wdata = 8'h11;
        cycle();
        chk("b2b_second", out_data[7:0], 8'h11);
        chk("b2b_valid", out_valid[0], 1);
        set_idle(); cpu_re = 1'b1; cpu_addr = 4'hD;
        cycle();
        chk("b2b_no_ovf", cpu_rdata, 8'h00);
        set_idle(); out_ready = 2'b01;
        cycle();
        set_idle();

        // status and unmapped reads
        in_valid = 2'b10; in_data = 16'hA500;
        cycle();
        in_valid = '0; cpu_we = 1'b1; cpu_addr = 4'h0; cpu_wdata = 8'h77;
        cycle();
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 4'h7;
        cycle();
        chk("unmapped_7", cpu_rdata, 8'h00);
        cpu_addr = 4'hE;
        cycle();
        chk("infull_mask", cpu_rdata, 8'h02);
        cpu_addr = 4'hF;
        cycle();
        chk("outbusy_mask", cpu_rdata, 8'h01);
        set_idle();

        // reset while busy[0] and full[1]
        pulse_reset();
        cycle();
        cycle();
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 2'b11);

`ifdef IO_IRQ_EN
        cpu_we = 1'b1; cpu_addr = 4'hC; cpu_wdata = 8'h01;
        cycle();
        set_idle(); in_valid = 2'b01; in_data = 16'h0042;
        cycle();
        set_idle();
        cycle();
        chk("irq_set", irq, 1);
        cpu_re = 1'b1; cpu_addr = 4'h0;
        cycle();
        set_idle();
        cycle();
        chk("irq_clear", irq, 0);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) != 0) cpu_addr = 4'($urandom_range(0, NP - 1));
            else                           cpu_addr = 4'($urandom_range(0, 15));
            cpu_we    = ($urandom_range(0, 2) == 0);
            cpu_re    = ($urandom_range(0, 2) == 0);
            cpu_wdata = W'($urandom());
            for (int i = 0; i < NP; i++) in_data[i*W +: W] = W'($urandom());
            in_valid  = NP'($urandom());
            out_ready = NP'($urandom());
            cycle();
            if ($urandom_range(0, 499) == 0) pulse_reset();
        end

        set_idle();
        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_io_port_bank
`default_nettype wire
